conv3x3_pipe: RTL and testbench

Pipelined, parametrised 3x3 convolution engine, the next generation of the combinational Gaussian compute block. It accepts one 3x3 window per beat with explicit image-edge flags and applies a runtime-loadable signed kernel with a selectable border mode. It then rounds, normalises by a programmable shift, clamps, and delivers results over a valid/ready stream. It sits between the line-buffer/window generator and the output pixel writer.

---
 rtl/conv3x3_pkg.sv | 18 +
 rtl/conv3x3_round_clamp.sv | 33 +++
 rtl/conv3x3_pipe.sv | 124 ++++++++++++
 tb/tb_conv3x3_pipe.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/conv3x3_pkg.sv
// Shared constants for the pipelined 3x3 convolution engine: default kernel,
// border modes, edge flag bit positions and the coefficient register map.
package conv3x3_pkg;
  localparam int NUM_TAPS = 9;
  localparam int STAGES = 3;
  localparam int DEFAULT_KERNEL [NUM_TAPS] = '{1, 2, 1, 2, 4, 2, 1, 2, 1};
  localparam int DEFAULT_SHIFT = 4;

  localparam logic BORDER_ZERO = 1'b0;
  localparam logic BORDER_REPLICATE = 1'b1;

  localparam int EDGE_LEFT = 0;
  localparam int EDGE_RIGHT = 1;
  localparam int EDGE_TOP = 2;
  localparam int EDGE_BOTTOM = 3;

  localparam logic [3:0] SHIFT_ADDR = 4'd9;
endpackage

// File: rtl/conv3x3_round_clamp.sv
// Round-half-up, arithmetic normalising shift and clamp to the pixel range.
module conv3x3_round_clamp #(
  parameter int ACC_WIDTH   = 17,
  parameter int DATA_WIDTH  = 8,
  parameter int SHIFT_WIDTH = 4
) (
  input  logic signed [ACC_WIDTH-1:0]   sum,
  input  logic        [SHIFT_WIDTH-1:0] shift,
  output logic        [DATA_WIDTH-1:0]  data,
  output logic                          sat
);
  // One guard bit so adding the rounding constant can never wrap.
  localparam int W = ACC_WIDTH + 1;
  localparam logic signed [W-1:0] MAX_PIX = W'((1 << DATA_WIDTH) - 1);

  logic signed [W-1:0] ext, half, shd;

  always_comb begin
    ext  = W'(sum);
    half = '0;
    if (shift != '0) half = W'(1) << (shift - SHIFT_WIDTH'(1));
    shd  = (ext + half) >>> shift;
    data = shd[DATA_WIDTH-1:0];
    sat  = 1'b0;
    if (shd < 0) begin
      data = '0;
      sat  = 1'b1;
    end else if (shd > MAX_PIX) begin
      data = '1;
      sat  = 1'b1;
    end
  end
endmodule

// File: rtl/conv3x3_pipe.sv
// 3-stage 3x3 convolution: S1 border mask + coefficient snapshot, S2 row
// partial sums, S3 round/clamp. Whole pipe stalls together on out_ready.
module conv3x3_pipe
  import conv3x3_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int COEF_WIDTH  = 5,
  parameter int SHIFT_WIDTH = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [9*DATA_WIDTH-1:0]   in_window,
  input  logic [3:0]                in_edge,
  input  logic                      cfg_border,
  input  logic                      coef_we,
  input  logic [3:0]                coef_addr,
  input  logic [COEF_WIDTH-1:0]     coef_wdata,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DATA_WIDTH-1:0]     out_data,
  output logic                      out_sat
);
  localparam int ACC_WIDTH = DATA_WIDTH + COEF_WIDTH + 4;
  localparam int PROD_WIDTH = DATA_WIDTH + COEF_WIDTH + 1;

  logic [STAGES:1] vld_pipe;
  logic            adv;

  assign adv       = !vld_pipe[STAGES] || out_ready;
  assign in_ready  = adv;
  assign out_valid = vld_pipe[STAGES];

  // Live coefficient/shift registers; writes land on the edge, so a beat
  // accepted on that same edge still snapshots the old values.
  logic [NUM_TAPS-1:0][COEF_WIDTH-1:0] coef_q;
  logic [SHIFT_WIDTH-1:0]              shift_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int t = 0; t < NUM_TAPS; t++) coef_q[t] <= COEF_WIDTH'(DEFAULT_KERNEL[t]);
      shift_q <= SHIFT_WIDTH'(DEFAULT_SHIFT);
    end else if (coef_we) begin
      for (int t = 0; t < NUM_TAPS; t++)
        if (coef_addr == 4'(t)) coef_q[t] <= coef_wdata;
      if (coef_addr == SHIFT_ADDR) shift_q <= coef_wdata[SHIFT_WIDTH-1:0];
    end
  end

  // Border masking: excluded rows/cols either zero out or fold onto the centre line.
  logic [NUM_TAPS-1:0][DATA_WIDTH-1:0] win, tap_m;
  assign win = in_window;

  for (genvar r = 0; r < 3; r++) begin : g_row
    for (genvar c = 0; c < 3; c++) begin : g_col
      logic       ex_r, ex_c;
      logic [3:0] src;
      assign ex_r = (r == 0 && in_edge[EDGE_TOP])  || (r == 2 && in_edge[EDGE_BOTTOM]);
      assign ex_c = (c == 0 && in_edge[EDGE_LEFT]) || (c == 2 && in_edge[EDGE_RIGHT]);
      assign src  = 4'((ex_r ? 1 : r) * 3 + (ex_c ? 1 : c));
      assign tap_m[r*3+c] = ((ex_r || ex_c) && cfg_border == BORDER_ZERO) ? '0 : win[src];
    end
  end

  logic [NUM_TAPS-1:0][DATA_WIDTH-1:0] tap_s1;
  logic [NUM_TAPS-1:0][COEF_WIDTH-1:0] coef_s1;
  logic [SHIFT_WIDTH-1:0]              shift_s1, shift_s2;

  logic signed [ACC_WIDTH-1:0] prod_ext [NUM_TAPS];
  for (genvar t = 0; t < NUM_TAPS; t++) begin : g_mul
    logic signed [DATA_WIDTH:0]   px;
    logic signed [COEF_WIDTH-1:0] cf;
    logic signed [PROD_WIDTH-1:0] prod;
    assign px   = signed'({1'b0, tap_s1[t]});
    assign cf   = signed'(coef_s1[t]);
    assign prod = px * cf;
    assign prod_ext[t] = ACC_WIDTH'(prod);
  end

  logic signed [ACC_WIDTH-1:0] row_c [3];
  logic signed [ACC_WIDTH-1:0] row_s2 [3];
  always_comb begin
    for (int r = 0; r < 3; r++) row_c[r] = prod_ext[r*3] + prod_ext[r*3+1] + prod_ext[r*3+2];
  end

  logic signed [ACC_WIDTH-1:0] acc_sum;
  logic [DATA_WIDTH-1:0]       rc_data;
  logic                        rc_sat;
  assign acc_sum = row_s2[0] + row_s2[1] + row_s2[2];

  conv3x3_round_clamp #(
    .ACC_WIDTH  (ACC_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .SHIFT_WIDTH(SHIFT_WIDTH)
  ) u_rc (
    .sum  (acc_sum),
    .shift(shift_s2),
    .data (rc_data),
    .sat  (rc_sat)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      tap_s1   <= '0;
      coef_s1  <= '0;
      shift_s1 <= '0;
      shift_s2 <= '0;
      for (int r = 0; r < 3; r++) row_s2[r] <= '0;
      out_data <= '0;
      out_sat  <= 1'b0;
    end else if (adv) begin
      vld_pipe <= {vld_pipe[STAGES-1:1], in_valid};
      tap_s1   <= tap_m;
      coef_s1  <= coef_q;
      shift_s1 <= shift_q;
      for (int r = 0; r < 3; r++) row_s2[r] <= row_c[r];
      shift_s2 <= shift_s1;
      out_data <= rc_data;
      out_sat  <= rc_sat;
    end
  end
endmodule

// File: tb/tb_conv3x3_pipe.sv
// Directed-vector bench for conv3x3_pipe with hand-computed expectations.
module tb_conv3x3_pipe;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, in_valid, in_ready, cfg_border, coef_we, out_valid, out_ready, out_sat;
  logic [71:0] in_window;
  logic [3:0]  in_edge, coef_addr;
  logic [4:0]  coef_wdata;
  logic [7:0]  out_data;

  int n_cmp = 0;
  int n_bad = 0;

  logic [71:0] beat_win [16];
  logic [7:0]  got_data [16];
  logic        got_sat  [16];
  int          got_n, stall_inflight, stall_unstable;

  conv3x3_pipe #(.DATA_WIDTH(8), .COEF_WIDTH(5), .SHIFT_WIDTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_window(in_window), .in_edge(in_edge), .cfg_border(cfg_border),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_wdata(coef_wdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_sat(out_sat)
  );

  function automatic logic [71:0] uni(input logic [7:0] v);
    return {9{v}};
  endfunction

  function automatic logic [71:0] mk(input logic [7:0] t0, t1, t2, t3, t4, t5, t6, t7, t8);
    return {t8, t7, t6, t5, t4, t3, t2, t1, t0};
  endfunction

  task automatic write_coef(input logic [3:0] a, input logic [4:0] d);
    coef_we = 1'b1; coef_addr = a; coef_wdata = d;
    @(posedge clk); #1;
    coef_we = 1'b0;
  endtask

  // One beat into an empty pipe; lat counts edges from the accept edge to out_valid.
  task automatic send_one(input logic [71:0] w, input logic [3:0] e, input logic b,
                          output logic [7:0] d, output logic s, output int lat);
    in_window = w; in_edge = e; cfg_border = b; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; lat = 1;
    while (out_valid !== 1'b1 && lat < 10) begin @(posedge clk); #1; lat++; end
    d = out_data; s = out_sat;
    @(posedge clk); #1;
  endtask

  // Streams beat_win[0..nb-1], stalls out_ready over [st_lo,st_hi), optional coef write.
  task automatic run_stream(input int nb, input int st_lo, input int st_hi,
                            input int wr_cyc, input logic [3:0] wa, input logic [4:0] wd);
    int i;
    logic fin, fout;
    logic [7:0] held;
    i = 0; got_n = 0; stall_inflight = -1; stall_unstable = 0; held = '0;
    in_edge = 4'b0; cfg_border = 1'b0;
    for (int c = 0; c < 60; c++) begin
      out_ready  = !(c >= st_lo && c < st_hi);
      in_valid   = (i < nb);
      in_window  = beat_win[(i < nb) ? i : 0];
      coef_we    = (c == wr_cyc); coef_addr = wa; coef_wdata = wd;
      #1;
      fin  = in_valid && in_ready;
      fout = out_valid && out_ready;
      if (!in_ready && stall_inflight < 0) begin stall_inflight = i - got_n; held = out_data; end
      if (!out_ready && out_valid && stall_inflight >= 0 && out_data !== held) stall_unstable++;
      if (fout && got_n < 16) begin got_data[got_n] = out_data; got_sat[got_n] = out_sat; got_n++; end
      @(posedge clk); #1;
      if (fin) i++;
    end
    in_valid = 1'b0; coef_we = 1'b0; out_ready = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_window = '0; in_edge = '0;
    cfg_border = 1'b0; coef_we = 1'b0; coef_addr = '0; coef_wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_cmp++; if (out_data !== 8'd0)  begin n_bad++; $display("FAIL reset_out_data: got %0d want 0", out_data); end
    n_cmp++; if (out_sat !== 1'b0)   begin n_bad++; $display("FAIL reset_out_sat: got %b want 0", out_sat); end
    n_cmp++; if (in_ready !== 1'b1)  begin n_bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    rst_n = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_interior();
    logic [7:0] d; logic s; int lat;
    send_one(uni(8'd100), 4'b0000, 1'b0, d, s, lat);
    n_cmp++; if (d !== 8'd100) begin n_bad++; $display("FAIL interior_data: got %0d want 100", d); end
    n_cmp++; if (s !== 1'b0)   begin n_bad++; $display("FAIL interior_sat: got %b want 0", s); end
    n_cmp++; if (lat != 3)     begin n_bad++; $display("FAIL interior_latency: got %0d want 3", lat); end
  endtask

  task automatic test_border();
    logic [71:0] w [7];
    logic [3:0]  e [7];
    logic        b [7];
    logic [7:0]  exp_d [7];
    logic [7:0]  d; logic s; int lat;
    w[0] = uni(8'd160); e[0] = 4'b0101; b[0] = 1'b0; exp_d[0] = 8'd90;
    w[1] = uni(8'd160); e[1] = 4'b0101; b[1] = 1'b1; exp_d[1] = 8'd160;
    w[2] = uni(8'd160); e[2] = 4'b1000; b[2] = 1'b0; exp_d[2] = 8'd120;
    w[3] = mk(0, 16, 255, 0, 16, 255, 0, 16, 255); e[3] = 4'b0011; b[3] = 1'b0; exp_d[3] = 8'd8;
    w[4] = w[3];                                   e[4] = 4'b0011; b[4] = 1'b1; exp_d[4] = 8'd16;
    w[5] = mk(10, 20, 30, 40, 50, 60, 70, 80, 90); e[5] = 4'b1010; b[5] = 1'b1; exp_d[5] = 8'd40;
    w[6] = w[5];                                   e[6] = 4'b1100; b[6] = 1'b0; exp_d[6] = 8'd25;
    for (int k = 0; k < 7; k++) begin
      send_one(w[k], e[k], b[k], d, s, lat);
      n_cmp++;
      if (d !== exp_d[k] || s !== 1'b0 || lat != 3) begin
        n_bad++;
        $display("FAIL border_%0d: got data %0d sat %b lat %0d want data %0d sat 0 lat 3", k, d, s, lat, exp_d[k]);
      end
    end
  endtask

  task automatic test_laplacian();
    logic [71:0] w [6];
    logic [7:0]  exp_d [6];
    logic        exp_s [6];
    logic [7:0]  d; logic s; int lat;
    for (int t = 0; t < 9; t++) write_coef(4'(t), (t == 4) ? 5'd8 : 5'h1F);
    write_coef(4'd9, 5'd0);
    write_coef(4'd12, 5'd3);
    w[0] = mk(0, 0, 0, 0, 200, 0, 0, 0, 0);       exp_d[0] = 8'd255; exp_s[0] = 1'b1;
    w[1] = mk(10, 10, 10, 10, 0, 10, 10, 10, 10); exp_d[1] = 8'd0;   exp_s[1] = 1'b1;
    w[2] = mk(2, 2, 2, 2, 30, 2, 2, 2, 2);        exp_d[2] = 8'd224; exp_s[2] = 1'b0;
    w[3] = uni(8'd50);                            exp_d[3] = 8'd0;   exp_s[3] = 1'b0;
    w[4] = mk(3, 0, 0, 0, 30, 0, 0, 0, 0);        exp_d[4] = 8'd119; exp_s[4] = 1'b0;
    w[5] = mk(3, 0, 0, 0, 0, 0, 0, 0, 0);         exp_d[5] = 8'd0;   exp_s[5] = 1'b1;
    for (int k = 0; k < 6; k++) begin
      if (k == 4) write_coef(4'd9, 5'd1);
      send_one(w[k], 4'b0000, 1'b0, d, s, lat);
      n_cmp++;
      if (d !== exp_d[k] || s !== exp_s[k]) begin
        n_bad++;
        $display("FAIL laplacian_%0d: got data %0d sat %b want data %0d sat %b", k, d, s, exp_d[k], exp_s[k]);
      end
    end
  endtask

  task automatic test_reset_midstream();
    logic [7:0] d; logic s; int lat, stale;
    write_coef(4'd4, 5'd0);
    out_ready = 1'b1; in_window = uni(8'd100); in_edge = '0; cfg_border = 1'b0; in_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    in_valid = 1'b0;
    n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL midrst_inflight: got %b want 1", out_valid); end
    rst_n = 1'b0;
    @(posedge clk); #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL midrst_valid_clear: got %b want 0", out_valid); end
    rst_n = 1'b1;
    stale = 0;
    repeat (6) begin @(posedge clk); #1; if (out_valid !== 1'b0) stale++; end
    n_cmp++; if (stale != 0) begin n_bad++; $display("FAIL midrst_stale: got %0d want 0", stale); end
    send_one(uni(8'd100), 4'b0000, 1'b0, d, s, lat);
    n_cmp++; if (d !== 8'd100 || lat != 3) begin n_bad++; $display("FAIL midrst_default_kernel: got %0d lat %0d want 100 lat 3", d, lat); end
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 6; k++) beat_win[k] = uni(8'((k + 1) * 10));
    run_stream(6, 4, 9, -1, 4'd0, 5'd0);
    n_cmp++; if (got_n != 6) begin n_bad++; $display("FAIL b2b_count: got %0d want 6", got_n); end
    for (int k = 0; k < 6; k++) begin
      n_cmp++;
      if (k >= got_n || got_data[k] !== 8'((k + 1) * 10) || got_sat[k] !== 1'b0) begin
        n_bad++;
        $display("FAIL b2b_out_%0d: got %0d want %0d", k, (k < got_n) ? got_data[k] : 8'd0, (k + 1) * 10);
      end
    end
    n_cmp++; if (stall_inflight != 3) begin n_bad++; $display("FAIL b2b_held: got %0d want 3", stall_inflight); end
    n_cmp++; if (stall_unstable != 0) begin n_bad++; $display("FAIL b2b_stable: got %0d want 0", stall_unstable); end
  endtask

  task automatic test_coef_inflight();
    logic [7:0] exp_d [4];
    exp_d[0] = 8'd100; exp_d[1] = 8'd100; exp_d[2] = 8'd100; exp_d[3] = 8'd75;
    for (int k = 0; k < 4; k++) beat_win[k] = uni(8'd100);
    run_stream(4, 99, 99, 2, 4'd4, 5'd0);
    n_cmp++; if (got_n != 4) begin n_bad++; $display("FAIL coef_count: got %0d want 4", got_n); end
    for (int k = 0; k < 4; k++) begin
      n_cmp++;
      if (k >= got_n || got_data[k] !== exp_d[k]) begin
        n_bad++;
        $display("FAIL coef_inflight_%0d: got %0d want %0d", k, (k < got_n) ? got_data[k] : 8'd0, exp_d[k]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_interior();
    test_border();
    test_laplacian();
    test_reset_midstream();
    test_back_to_back();
    test_coef_inflight();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end
endmodule
